// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and constants for the PC unit
// Purpose: redirect source encoding (also its priority), default vectors and
//          the pending-redirect entry stored while the pipeline is stalled.
// Ports:   none (package).
package pc_pkg;

    // Source code doubles as priority: a larger value wins arbitration.
    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_BR   = 3'd1,
        SRC_JMP  = 3'd2,
        SRC_ERET = 3'd3,
        SRC_EXC  = 3'd4
    } pc_src_e;

    localparam logic [31:0] PC_DEF_RESET_VECTOR = 32'h0040_0000;
    localparam logic [31:0] PC_DEF_EXC_VECTOR   = 32'h0040_0004;

    // The stored target is sized for the widest supported PC (XLEN <= 64).
    // Narrower instances zero-extend on write and truncate on read.
    localparam int PC_TGT_W = 64;

    typedef struct packed {
        pc_src_e               src;
        logic [PC_TGT_W-1:0]   target;
    } pend_t;

endpackage

// File: rtl/pc_incr.sv
// rtl/pc_incr.sv - combinational sequential-PC adder
// Purpose: pc_plus_o = pc_i + INSTR_BYTES, modulo 2^XLEN, no carry out.
//          Shared with the link-address logic.
// Ports:   pc_i      current PC
//          pc_plus_o next sequential PC
module pc_incr #(
    parameter int XLEN        = 32,
    parameter int INSTR_BYTES = 4
) (
    input  logic [XLEN-1:0] pc_i,
    output logic [XLEN-1:0] pc_plus_o
);

    assign pc_plus_o = pc_i + XLEN'(INSTR_BYTES);

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - architectural PC register with redirect arbitration
// Purpose: selects the next PC from sequential increment, branch, jump,
//          eret and exception; holds on stall and remembers the strongest
//          redirect seen during a stall in a one-entry buffer.
// Ports:   clk, rst (sync, active-high)
//          stall                 hold PC this cycle
//          br_taken/br_target    conditional branch redirect
//          jmp/jmp_target        jump redirect
//          exc                   exception, target EXC_VECTOR
//          eret/epc              return from exception
//          pc, pc_plus           current PC and PC + INSTR_BYTES
//          redirect_pending      buffered redirect waiting for un-stall
//          misalign              one-cycle pulse after an unaligned target
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter int              INSTR_BYTES  = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_DEF_RESET_VECTOR),
    parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(PC_DEF_EXC_VECTOR)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    input  logic            jmp,
    input  logic [XLEN-1:0] jmp_target,
    input  logic            exc,
    input  logic            eret,
    input  logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_plus,
    output logic            redirect_pending,
    output logic            misalign
);

    // Low address bits that must be zero for an aligned instruction fetch.
    localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INSTR_BYTES - 1);

    logic [XLEN-1:0] pc_q, pc_d;
    pend_t           pend_q, pend_d;
    logic            misalign_q, misalign_d;

    pc_src_e         live_src, win_src;
    logic [XLEN-1:0] live_tgt, win_tgt;

    pc_incr #(
        .XLEN        (XLEN),
        .INSTR_BYTES (INSTR_BYTES)
    ) u_incr (
        .pc_i      (pc_q),
        .pc_plus_o (pc_plus)
    );

    // Highest-priority redirect requested this cycle.
    always_comb begin
        live_src = SRC_NONE;
        live_tgt = pc_plus;
        if (exc) begin
            live_src = SRC_EXC;
            live_tgt = EXC_VECTOR;
        end else if (eret) begin
            live_src = SRC_ERET;
            live_tgt = epc;
        end else if (jmp) begin
            live_src = SRC_JMP;
            live_tgt = jmp_target;
        end else if (br_taken) begin
            live_src = SRC_BR;
            live_tgt = br_target;
        end
    end

    // Buffered entry only wins when strictly stronger; ties go to the live
    // request since it reflects the newer pipeline state.
    always_comb begin
        win_src    = live_src;
        win_tgt    = live_tgt;
        pc_d       = pc_q;
        pend_d     = pend_q;
        misalign_d = 1'b0;

        if (pend_q.src > live_src) begin
            win_src = pend_q.src;
            win_tgt = XLEN'(pend_q.target);
        end

        if (!stall) begin
            pend_d = '0;
            if (win_src != SRC_NONE) begin
                pc_d       = win_tgt & ~LOW_MASK;
                misalign_d = |(win_tgt & LOW_MASK);
            end else begin
                pc_d = pc_plus;
            end
        end else if (win_src != SRC_NONE) begin
            // Rewriting with the winner keeps a stronger older entry intact
            // and lets an equal or stronger live request replace it.
            pend_d.src    = win_src;
            pend_d.target = PC_TGT_W'(win_tgt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            pend_q     <= '0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc               = pc_q;
    assign redirect_pending = (pend_q.src != SRC_NONE);
    assign misalign         = misalign_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - self-checking bench for pc_unit
module tb_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        redirect_pending;
    logic        misalign;

    pc_unit dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .jmp              (jmp),
        .jmp_target       (jmp_target),
        .exc              (exc),
        .eret             (eret),
        .epc              (epc),
        .pc               (pc),
        .pc_plus          (pc_plus),
        .redirect_pending (redirect_pending),
        .misalign         (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [31:0] br_t;
        logic        jmp;
        logic [31:0] jmp_t;
        logic        exc;
        logic        eret;
        logic [31:0] epc;
        logic [31:0] exp_pc;
        logic        exp_pend;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    function automatic vec_t mk(logic r, logic s, logic b, logic [31:0] bt,
                                logic j, logic [31:0] jt, logic x, logic e,
                                logic [31:0] ep, logic [31:0] xpc, logic xp,
                                logic xm);
        vec_t v;
        v.rst = r; v.stall = s; v.br = b; v.br_t = bt; v.jmp = j; v.jmp_t = jt;
        v.exc = x; v.eret = e; v.epc = ep;
        v.exp_pc = xpc; v.exp_pend = xp; v.exp_mis = xm;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, step_no, act, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic step(input vec_t v);
        vec_t e;
        rst = v.rst; stall = v.stall;
        br_taken = v.br; br_target = v.br_t;
        jmp = v.jmp; jmp_target = v.jmp_t;
        exc = v.exc; eret = v.eret; epc = v.epc;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard step %0d: queue empty", step_no);
        end else begin
            e = exp_q.pop_front();
            chk("pc", pc, e.exp_pc);
            chk("pc_plus", pc_plus, e.exp_pc + 32'd4);
            chk("redirect_pending", {31'd0, redirect_pending}, {31'd0, e.exp_pend});
            chk("misalign", {31'd0, misalign}, {31'd0, e.exp_mis});
        end
        step_no++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
        jmp = 1'b0; jmp_target = '0; exc = 1'b0; eret = 1'b0; epc = '0;
        @(negedge clk);

        //            rst stl br brt           jmp jt            exc ert epc           exp_pc        pend mis
        vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0040_0000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0040_0004, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0040_0008, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0040_000C, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0040_0010, 0, 0));
        // jmp beats br in the same cycle
        vecs.push_back(mk(0, 0, 1, 32'h0040_0100, 1, 32'h0040_0200, 0, 0, 32'h0,        32'h0040_0200, 0, 0));
        // 3-cycle stall with a branch in the first cycle
        vecs.push_back(mk(0, 1, 1, 32'h0040_0300, 0, 32'h0,        0, 0, 32'h0,        32'h0040_0200, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0040_0200, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0040_0200, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0040_0300, 0, 0));
        // pending branch replaced by exc during stall
        vecs.push_back(mk(0, 1, 1, 32'h0040_0400, 0, 32'h0,        0, 0, 32'h0,        32'h0040_0300, 1, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0040_0300, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0040_0004, 0, 0));
        // pending jmp beats live br on the un-stall cycle
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h0040_0600, 0, 0, 32'h0,        32'h0040_0004, 1, 0));
        vecs.push_back(mk(0, 0, 1, 32'h0040_0700, 0, 32'h0,        0, 0, 32'h0,        32'h0040_0600, 0, 0));
        // unaligned jump target, misalign for exactly one cycle
        vecs.push_back(mk(0, 0, 0, 32'h0,        1, 32'h0040_0203, 0, 0, 32'h0,        32'h0040_0200, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0040_0204, 0, 0));
        // equal priority: live br beats pending br
        vecs.push_back(mk(0, 1, 1, 32'h0040_0800, 0, 32'h0,        0, 0, 32'h0,        32'h0040_0204, 1, 0));
        vecs.push_back(mk(0, 0, 1, 32'h0040_0900, 0, 32'h0,        0, 0, 32'h0,        32'h0040_0900, 0, 0));
        // eret, then exc beats eret
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0040_0A00, 32'h0040_0A00, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h0040_0B00, 32'h0040_0004, 0, 0));
        // live eret beats pending jmp
        vecs.push_back(mk(0, 1, 0, 32'h0,        1, 32'h0040_1000, 0, 0, 32'h0,        32'h0040_0004, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0040_2000, 32'h0040_2000, 0, 0));
        // pending exc survives a weaker live br during stall
        vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        32'h0040_2000, 1, 0));
        vecs.push_back(mk(0, 1, 1, 32'h0040_3000, 0, 32'h0,        0, 0, 32'h0,        32'h0040_2000, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0040_0004, 0, 0));
        // unaligned pending branch applied after stall
        vecs.push_back(mk(0, 1, 1, 32'h0040_4002, 0, 32'h0,        0, 0, 32'h0,        32'h0040_0004, 1, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h0040_4000, 0, 1));

        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // Wrap-around of the sequential increment.
        step(mk(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0, 32'hFFFF_FFFC, 0, 0));
        step(mk(0, 0, 0, 32'h0, 0, 32'h0,         0, 0, 32'h0, 32'h0000_0000, 0, 0));
        step(mk(0, 0, 0, 32'h0, 0, 32'h0,         0, 0, 32'h0, 32'h0000_0004, 0, 0));

        // Reset mid-stall discards a pending eret.
        step(mk(0, 1, 0, 32'h0, 0, 32'h0, 0, 1, 32'h0040_0500, 32'h0000_0004, 1, 0));
        step(mk(0, 1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0,         32'h0000_0004, 1, 0));
        step(mk(1, 1, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0,         32'h0040_0000, 0, 0));
        step(mk(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0,         32'h0040_0004, 0, 0));
        step(mk(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0,         32'h0040_0008, 0, 0));

        // Redirect inputs ignored while rst is high.
        step(mk(1, 0, 1, 32'h0040_7000, 1, 32'h0040_8003, 1, 1, 32'h0040_9000, 32'h0040_0000, 0, 0));
        step(mk(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 32'h0,         32'h0040_0004, 0, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor to the combinational PC incrementer.
- Holds the architectural PC register and selects the next PC from sequential increment, branch, jump/jr, exception and eret redirects.
- Supports pipeline stall, with a one-entry pending-redirect buffer so a redirect raised during a stall is not lost.
- Sits at the front of the 54-instruction CPU; drives the instruction-memory address and exports pc+INSTR_BYTES for link/delay-slot logic.

Parameters:
- XLEN, 32, PC/address width.
- INSTR_BYTES, 4, sequential increment.
- RESET_VECTOR, 32'h0040_0000, PC after reset.
- EXC_VECTOR, 32'h0040_0004, target on exception.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC this cycle.
- br_taken  in  1  conditional branch taken.
- br_target  in  XLEN  branch target.
- jmp  in  1  j/jal/jr/jalr.
- jmp_target  in  XLEN  jump target.
- exc  in  1  exception/interrupt request.
- eret  in  1  return from exception.
- epc  in  XLEN  eret target.
- pc  out  XLEN  current PC.
- pc_plus  out  XLEN  pc+INSTR_BYTES (combinational from pc).
- redirect_pending  out  1  a buffered redirect awaits un-stall.
- misalign  out  1  one-cycle pulse: the applied target had nonzero low bits.

Behaviour:
- One clock; rst is synchronous and active-high. On rst: pc=RESET_VECTOR, pending buffer cleared, redirect_pending=0, misalign=0. rst overrides every other input, including mid-stall with a pending redirect; the pending redirect is discarded.
- Priority, highest first: exc(4) > eret(3) > jmp(2) > br_taken(1) > sequential(0). Live candidate = highest asserted source this cycle; its target is EXC_VECTOR, epc, jmp_target or br_target respectively.
- Arbitration between live candidate and pending buffer: the higher priority wins; on equal priority the live candidate wins.
- Not stalled: pc <= winner target, or pc_plus if there is no winner. Pending buffer is cleared the same edge. Latency is one edge from request to pc update.
- Stalled: pc holds. If a winner exists it is written into the pending buffer (priority and target), and redirect_pending=1 from the next cycle.
- exc during stall always overwrites the buffer.
- Buffer holds across any stall length. It is applied on the first non-stalled edge unless a higher- or equal-priority live request arrives that cycle.
- Alignment: applied target has its low log2(INSTR_BYTES) bits forced to 0. misalign=1 for the cycle after the edge that applied an unaligned target; else 0. Sequential increments never set misalign.
- Wrap-around: pc+INSTR_BYTES is modulo 2^XLEN (0xFFFF_FFFC -> 0x0000_0000), no flag.
- All redirect inputs are ignored while rst=1.

Decomposition:
- Shared package pc_pkg holds:
  - redirect source encoding SRC_NONE=0, SRC_BR=1, SRC_JMP=2, SRC_ERET=3, SRC_EXC=4 (3-bit);
  - default RESET_VECTOR/EXC_VECTOR constants;
  - the pending-entry struct {src, target}.
- One natural sub-module: pc_incr. It is the parametrised combinational adder (XLEN, INSTR_BYTES) producing pc_plus, reused by link-address logic.

Test Plan:
- Reset, then 3 free-running cycles -> pc 0x00400000, 0x00400004, 0x00400008, 0x0040000C; redirect_pending=0.
- pc=0x00400010; br_taken with br_target=0x00400100 and jmp with jmp_target=0x00400200 in the same cycle -> next pc=0x00400200.
- stall=1 for 3 cycles; br_taken (0x00400300) pulsed in cycle 1 -> pc holds, redirect_pending=1 from cycle 2. First un-stalled edge -> pc=0x00400300, redirect_pending=0.
- Stalled with pending branch; exc pulsed -> buffer replaced. Un-stall -> pc=EXC_VECTOR 0x00400004. Separately, with a pending jmp and a live br on the un-stall cycle -> jmp target applied.
- jmp_target=0x00400203 -> pc=0x00400200, misalign=1 for exactly one cycle. Separately, force pc=0xFFFFFFFC via jmp -> next sequential pc=0x00000000.
- rst asserted while stalled with a pending eret (epc=0x00400500) -> pc=0x00400000, redirect_pending=0. After rst drops, pc increments sequentially and the old eret is never applied.
